// File: rtl/out_uart_bridge_if.sv
// Signal bundle between the cpu `out` port and the UART bridge.
// The cpu side (master) presents its output word; the bridge (slave) reports line and FIFO status.
interface out_uart_bridge_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]    cpu_out;
  logic                     tx;
  logic                     busy;
  logic [FIFO_ADDR_WIDTH:0] level;
  logic                     overflow;
  logic [1:0]               dbg_state;

  modport master (
    output cpu_out,
    input  tx, busy, level, overflow, dbg_state
  );

  modport slave (
    input  cpu_out,
    output tx, busy, level, overflow, dbg_state
  );
endinterface

// File: rtl/out_uart_bridge.sv
// Captures every change of the cpu output word into a small FIFO and sends
// each word over an 8N1 UART line, high byte first, low byte immediately after.
module out_uart_bridge #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int CLKS_PER_BIT    = 4
) (
  input logic              clk,
  input logic              rst_n,
  out_uart_bridge_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]              CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0]   FULL_LEVEL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    prev_q;
  logic [DATA_WIDTH-1:0]    word_q;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [FIFO_ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [FIFO_ADDR_WIDTH:0] level;
  logic [CW-1:0]            clk_cnt_q;
  logic [2:0]               bit_idx_q;
  logic                     byte_sel_q;
  logic                     tx_q;
  logic                     overflow_q;
  logic                     push, pop, full, accept;
  logic [7:0]               cur_byte;

  // Producer contract: there is no valid/ready pair; a word is offered whenever
  // cpu_out differs from the last sampled value, and it is taken unless the FIFO
  // is full with no pop on the same edge, in which case it is dropped and flagged.
  assign level    = wptr_q - rptr_q;
  assign full     = (level == FULL_LEVEL);
  assign push     = (bus.cpu_out != prev_q);
  assign pop      = (state_q == IDLE) && (level != '0);
  assign accept   = push && (!full || pop);
  assign wptr_d   = accept ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d   = pop    ? rptr_q + 1'b1 : rptr_q;
  assign cur_byte = byte_sel_q ? word_q[7:0] : word_q[DATA_WIDTH-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q <= bus.cpu_out;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q[FIFO_ADDR_WIDTH-1:0]] <= bus.cpu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            word_q     <= mem_q[rptr_q[FIFO_ADDR_WIDTH-1:0]];
            byte_sel_q <= 1'b0;
            clk_cnt_q  <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_MAX) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_MAX) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_MAX) begin
            clk_cnt_q <= '0;
            if (!byte_sel_q) begin
              byte_sel_q <= 1'b1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = (state_q != IDLE) || (level != '0);
  assign bus.level     = level;
  assign bus.overflow  = overflow_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_out_uart_bridge.sv
// Bench for out_uart_bridge: directed scenarios plus random word streams, with a
// word-level reference model feeding an expected queue drained by a UART receiver.
module tb_out_uart_bridge;
  localparam int DW       = 16;
  localparam int AW       = 2;
  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = 20 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  out_uart_bridge_if #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) bus ();

  out_uart_bridge #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Word-level view: a change is offered each edge, the transmitter is either
  // free or busy for a whole word time, and the buffer holds at most DEPTH words.
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_prev;
  int            m_tx_left;
  logic          m_ovf;
  bit            m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev    = '0;
      m_fifo.delete();
      exp_q.delete();
      m_tx_left = 0;
      m_ovf     = 1'b0;
    end else begin
      m_pop = (m_tx_left == 0) && (m_fifo.size() != 0);
      if (m_tx_left > 0) m_tx_left--;
      if (m_pop) begin
        exp_q.push_back(m_fifo.pop_front());
        m_tx_left = WORD_CYC;
      end
      if (bus.cpu_out != m_prev) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(bus.cpu_out);
        else m_ovf = 1'b1;
      end
      m_prev = bus.cpu_out;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit        rx_active = 0;
  bit        have_hi   = 0;
  int        rx_cnt    = 0;
  int        gap_cnt   = 0;
  int        rx_words  = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_hi;

  task automatic byte_done(input logic [7:0] b);
    logic [DW-1:0] w;
    if (!have_hi) begin
      rx_hi   = b;
      have_hi = 1;
      gap_cnt = 0;
    end else begin
      have_hi = 0;
      w = {rx_hi, b};
      rx_words++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", w, $time);
      end else begin
        check("word", w, exp_q.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 0;
      have_hi   = 0;
      gap_cnt   = 0;
    end else begin
      check("level", bus.level, m_fifo.size());
      check("busy", bus.busy, (m_tx_left != 0) || (m_fifo.size() != 0));
      check("overflow", bus.overflow, m_ovf);
      if (m_tx_left == 0) check("tx_idle", bus.tx, 1);
      if (!rx_active) begin
        if (bus.tx == 1'b0) begin
          if (have_hi) check("byte_gap", gap_cnt, CPB / 2 - 1);
          rx_active = 1;
          rx_cnt    = 0;
          rx_byte   = '0;
        end else if (have_hi) begin
          gap_cnt++;
          if (gap_cnt == CPB + 1) begin
            checks++;
            errors++;
            $display("FAIL low_byte_missing: got idle line expected start bit at %0t", $time);
            have_hi = 0;
          end
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CPB / 2) begin
          check("start_bit", bus.tx, 0);
        end else if (rx_cnt == 9 * CPB + CPB / 2) begin
          check("stop_bit", bus.tx, 1);
          rx_active = 0;
          byte_done(rx_byte);
        end else if (rx_cnt > CPB && rx_cnt < 9 * CPB && ((rx_cnt - CPB / 2) % CPB) == 0) begin
          rx_byte[(rx_cnt - CPB / 2) / CPB - 1] = bus.tx;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [DW-1:0] v);
    @(negedge clk);
    bus.cpu_out = v;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || m_tx_left != 0 || rx_active || have_hi) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    int r;
    logic [DW-1:0] v;

    bus.cpu_out = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_level", bus.level, 0);
    check("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_frame_after_reset", rx_words, 0);

    // single word with latency and duration checks
    base = rx_words;
    drive(16'h0008);
    @(posedge clk); #1;
    check("push_level", bus.level, 1);
    check("tx_before_pop", bus.tx, 1);
    @(posedge clk); #1;
    check("tx_start_after_pop", bus.tx, 0);
    check("level_after_pop", bus.level, 0);
    n = 1;
    while (bus.busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_cycles", n, 81);
    wait_drain(200);
    check("single_word_count", rx_words - base, 1);

    // repeated value then a short sequence
    do_reset();
    base = rx_words;
    drive(16'h0008);
    repeat (50) @(negedge clk);
    drive(16'h0009);
    repeat (3) @(negedge clk);
    drive(16'h0003);
    wait_drain(600);
    check("sequence_count", rx_words - base, 3);

    // overflow: changes every cycle
    do_reset();
    base = rx_words;
    for (int i = 1; i <= 7; i++) drive(DW'(i));
    @(negedge clk);
    check("ovf_level", bus.level, 4);
    check("ovf_flag", bus.overflow, 1);
    wait_drain(800);
    check("ovf_count", rx_words - base, 5);

    // push on the pop edge while full
    do_reset();
    base = rx_words;
    for (int i = 1; i <= 5; i++) drive(DW'(i));
    repeat (78) @(negedge clk);
    bus.cpu_out = 16'h0006;
    @(posedge clk); #1;
    check("full_pop_level", bus.level, 4);
    check("full_pop_overflow", bus.overflow, 0);
    wait_drain(900);
    check("full_pop_count", rx_words - base, 6);
    check("full_pop_overflow_end", bus.overflow, 0);

    // reset in the middle of the high byte
    do_reset();
    base = rx_words;
    drive(16'h0012);
    drive(16'h0034);
    repeat (12) @(negedge clk);
    check("mid_frame_tx_low", bus.tx, 0);
    check("mid_frame_level", bus.level, 1);
    #2;
    rst_n = 1'b0;
    bus.cpu_out = '0;
    #1;
    check("async_rst_tx", bus.tx, 1);
    check("async_rst_level", bus.level, 0);
    check("async_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    check("no_residual_frame", rx_words - base, 0);

    // random streams with repeats, bursts and idle stretches
    do_reset();
    v = '0;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 3);
      if (r == 1) v = DW'($urandom_range(0, 3));
      else if (r >= 2) v = DW'($urandom);
      drive(v);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_drain(3000);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/out_uart_bridge.md
Name: out_uart_bridge

Overview:
- Downstream consumer of the cpu `out` port: detects each change of the cpu output word, buffers it in a small FIFO and serializes it over a UART TX line (8N1, high byte first).
- Sits beside the cpu in the top-level, clocked by the same divided clock as cpu/memory.
- Gives the simulated and FPGA builds an observable output stream without an unbounded $strobe trace.

Parameters:
- DATA_WIDTH, 16, width of captured cpu output word; must be 16 (two UART bytes).
- FIFO_ADDR_WIDTH, 2, FIFO depth = 2**FIFO_ADDR_WIDTH words (default 4).
- CLKS_PER_BIT, 4, clk cycles per UART bit; must be >= 2.

Ports:
- clk  input  1  divided system clock (same as cpu clk)
- rst_n  input  1  reset, asynchronous, active-low
- cpu_out  input  DATA_WIDTH  cpu `out` port
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is in progress or FIFO non-empty
- level  output  FIFO_ADDR_WIDTH+1  current FIFO occupancy
- overflow  output  1  sticky: a change was dropped because FIFO was full

Behaviour:
- Reset (async, rst_n low): tx=1, busy=0, level=0, overflow=0, prev_q=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts immediately; tx returns high asynchronously; FIFO contents discarded.
- Change detect: at each rising edge, if cpu_out != prev_q then prev_q<=cpu_out and a push of cpu_out is requested. Value 0 after reset is not pushed (prev_q resets to 0). Repeated identical values are not pushed.
- FIFO: circular, write/read pointers FIFO_ADDR_WIDTH+1 bits wide (wrap bit distinguishes full from empty). Push when full is dropped and sets overflow (sticky until reset), EXCEPT if a pop occurs the same edge: then the push is accepted and level is unchanged. Simultaneous push and pop when empty: FSM only pops when level != 0 at the edge, so the new word is popped on a later edge.
- FSM states: IDLE, START, DATA, STOP. Counters: clk_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7), byte_sel (0=high byte, 1=low byte).
- IDLE: tx=1. If level != 0: pop head into shift word, byte_sel<=0, clk_cnt<=0, go START with tx<=0 at that same edge.
- START: tx=0 for CLKS_PER_BIT cycles, then go DATA, bit_idx<=0.
- DATA: tx = current byte bit bit_idx (LSB first), each bit held CLKS_PER_BIT cycles; after bit 7, go STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then if byte_sel=0: byte_sel<=1, go START (low byte, no idle gap). If byte_sel=1: go IDLE.
- Frame = 10*CLKS_PER_BIT cycles; one word = 20*CLKS_PER_BIT cycles plus one IDLE cycle before the next pop.
- Latency: cpu_out change sampled at edge k -> pushed at edge k; popped at edge k+1 if FSM idle; tx falls after edge k+1.
- tx is registered (no glitches). busy = (state != IDLE) | (level != 0).
- cpu_out is assumed synchronous to clk; no synchronizer.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> tx=1, busy=0, level=0, overflow=0; release with cpu_out=0 -> no frame sent.
- Single word: CLKS_PER_BIT=4, cpu_out 0->16'h0008 at edge k -> tx low after edge k+1; decoded frames 8'h00 then 8'h08, each 40 cycles, back-to-back; busy drops after 80+1 cycles; level returns to 0.
- Repeat/sequence: cpu_out 8, held 50 cycles, then 9, then 3 -> exactly three words 0x0008,0x0009,0x0003 transmitted in order, no duplicates.
- Overflow: change cpu_out every cycle 1..7 while first frame in flight -> level saturates at 4, overflow=1; received words are 1,2,3,4,5 (one popped immediately, four buffered); 6 and 7 dropped.
- Push-while-full-and-pop: fill FIFO to 4, present new value on the edge the FSM pops -> value accepted, level stays 4, overflow stays 0.
- Mid-frame reset: assert rst_n during DATA of the high byte -> tx=1 immediately (before next clk edge), level=0; after release no residual frame is sent.
